// File: rtl/dmem_responder_if.sv
// Valid/ready request and response bundle between the MEM-stage pipeline (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states and byte-enabled stores.
// Optional out-of-range detection is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic          ready_q;
   logic          accept;
   logic          addr_err;

   logic          we_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;
   logic          err_q;

   logic [31:0]   rdata_q;
   logic          rsp_err_q;

   logic [31:0]   mem [DEPTH];

`ifdef DMEM_RANGE_CHECK_EN
   logic unused_addr_lo;
   assign addr_err       = |bus.req_addr[31:AW+2];
   assign unused_addr_lo = ^bus.req_addr[1:0];
`else
   logic unused_addr_bits;
   assign addr_err         = 1'b0;
   assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
`endif

   // ready is a separate register so it is low throughout reset yet still comes only from flops
   assign accept        = bus.req_valid && ready_q;
   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_n = S_EXEC;
               end else begin
                  state_n = S_WAIT;
                  cnt_n   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) state_n = S_EXEC;
            else             cnt_n   = cnt - 4'd1;
         end
         S_EXEC:  state_n = S_RESP;
         S_RESP:  if (bus.rsp_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ready_q <= (state_n == S_IDLE);
         if (state == S_EXEC) begin
            rsp_err_q <= err_q;
            rdata_q   <= (we_q || err_q) ? '0 : mem[idx_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         idx_q   <= bus.req_addr[AW+1:2];
         wdata_q <= bus.req_wdata;
         be_q    <= bus.req_be;
         err_q   <= addr_err;
      end
   end

   // Array is not reset: a store that reached EXEC commits even if reset arrives on that edge
   always_ff @(posedge clk) begin
      if (state == S_EXEC && we_q && !err_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WAIT_CYCLES=2 instance for directed tests,
// WAIT_CYCLES=0 instance for back-to-back throughput against a reference memory.
module tb_dmem_responder;
   localparam int unsigned W = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;
   exp_t        q[$];
   exp_t        q0[$];
   bit          seen = 0;
   bit          seen0 = 0;
   logic [31:0] refm [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder_if bus ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(W)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitors sample 2 time units after the falling edge so inputs driven on that edge are settled
   always @(negedge clk) begin
      #2;
      if (rst) seen = 0;
      else if (bus.rsp_valid) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp got rsp_valid=1 exp no pending request (t=%0t)", $time);
         end else begin
            if (!seen) begin
               chk("latency", cyc - q[0].acc, 2 + W);
               seen = 1;
            end
            chk("rsp_rdata", bus.rsp_rdata, q[0].rdata);
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, q[0].err});
            if (bus.rsp_ready) begin
               void'(q.pop_front());
               seen = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (rst) seen0 = 0;
      else if (bus0.rsp_valid) begin
         if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp0 got rsp_valid=1 exp no pending request (t=%0t)", $time);
         end else begin
            if (!seen0) begin
               chk("latency0", cyc - q0[0].acc, 2);
               seen0 = 1;
            end
            chk("rsp_rdata0", bus0.rsp_rdata, q0[0].rdata);
            chk("rsp_err0", {31'd0, bus0.rsp_err}, {31'd0, q0[0].err});
            if (bus0.rsp_ready) begin
               void'(q0.pop_front());
               seen0 = 0;
            end
         end
      end
   end

   // Called on a falling edge; returns on the falling edge after the accepting rising edge
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
      int unsigned n = 0;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
      bus.req_wdata = wdata; bus.req_be = be;
      while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
      if (!bus.req_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout got req_ready=0 exp 1 within 200 cycles");
      end else q.push_back('{exp_rd, exp_err, cyc});
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic issue0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rd, output int unsigned acc);
      int unsigned n = 0;
      bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_addr = addr;
      bus0.req_wdata = wdata; bus0.req_be = be;
      while (!bus0.req_ready && n < 200) begin @(negedge clk); n++; end
      acc = cyc;
      if (!bus0.req_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout0 got req_ready=0 exp 1 within 200 cycles");
      end else q0.push_back('{exp_rd, 1'b0, cyc});
      @(negedge clk);
      bus0.req_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((q.size() != 0 || q0.size() != 0) && n < 500) begin @(negedge clk); n++; end
      if (q.size() != 0 || q0.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout got pending=%0d exp 0", q.size() + q0.size());
      end
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout got still running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned acc, prev_acc, n;
      logic [31:0] wd, mask;
      logic [3:0]  be;
      logic        we;
      int unsigned idx;

      bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = '0;
      bus.req_wdata  = '0;   bus.req_be  = '0;   bus.rsp_ready = 1'b1;
      bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
      bus0.req_wdata = '0;   bus0.req_be = '0;   bus0.rsp_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      chk("rst_req_ready0", {31'd0, bus0.req_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

      // basic store/load
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
      // partial byte enables
      issue(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
      issue(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
      // zero byte enable writes nothing
      issue(1'b1, 32'h40, 32'h00000055, 4'hF, 32'h0, 1'b0);
      issue(1'b1, 32'h40, 32'h99999999, 4'h0, 32'h0, 1'b0);
      issue(1'b0, 32'h40, 32'h0, 4'h0, 32'h00000055, 1'b0);
      drain();

      // response backpressure for 7 cycles
      bus.rsp_ready = 1'b0;
      issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
      for (int k = 0; k < 7; k++) begin
         chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
         chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("idle_after_hold", {31'd0, bus.req_ready}, 32'd1);
      chk("valid_drop_after_hold", {31'd0, bus.rsp_valid}, 32'd0);

      // reset while a load sits in WAIT
      issue(1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0);
      drain();
      issue(1'b0, 32'h30, 32'h0, 4'h0, 32'h12345678, 1'b0);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_release_ready", {31'd0, bus.req_ready}, 32'd1);
      for (int k = 0; k < 8; k++) begin
         chk("no_rsp_after_rst", {31'd0, bus.rsp_valid}, 32'd0);
         @(negedge clk);
      end
      issue(1'b0, 32'h30, 32'h0, 4'h0, 32'h12345678, 1'b0);

      // out-of-range store
      issue(1'b1, 32'h0, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
      issue(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
      issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h0BADC0DE, 1'b0);
`else
      issue(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
      issue(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
`endif
      drain();

      // zero-wait instance: back-to-back traffic against a reference model
      prev_acc = 0;
      for (int i = 0; i < 8; i++) begin
         wd = $urandom;
         refm[i] = wd;
         issue0(1'b1, 32'h100 + 32'(4 * i), wd, 4'hF, 32'h0, acc);
         if (i > 0) chk("throughput", acc - prev_acc, 32'd3);
         prev_acc = acc;
      end
      for (int i = 0; i < 20; i++) begin
         we  = 1'($urandom_range(0, 1));
         idx = $urandom_range(0, 7);
         wd  = $urandom;
         be  = 4'($urandom_range(0, 15));
         if (we) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            refm[idx] = (refm[idx] & ~mask) | (wd & mask);
            issue0(1'b1, 32'h100 + 32'(4 * idx), wd, be, 32'h0, acc);
         end else begin
            issue0(1'b0, 32'h100 + 32'(4 * idx), 32'h0, 4'h0, refm[idx], acc);
         end
         chk("throughput", acc - prev_acc, 32'd3);
         prev_acc = acc;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
